// File: rtl/digit_pkg.sv
// Shared canvas geometry and scanner state encoding.
package digit_pkg;

  localparam int unsigned SRC_W = 56;
  localparam int unsigned SRC_H = 56;
  localparam int unsigned BLK   = 2;
  localparam int unsigned OUT_W = SRC_W / BLK;
  localparam int unsigned OUT_H = SRC_H / BLK;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StEmit,
    StFinish
  } state_e;

endpackage

// File: rtl/pixel_block_scanner_if.sv
// Block stream from the scanner to the downstream averager.
interface pixel_block_scanner_if #(
  parameter int unsigned PIX_W = digit_pkg::BLK * digit_pkg::BLK,
  parameter int unsigned IDX_W = $clog2(digit_pkg::OUT_W * digit_pkg::OUT_H)
);

  logic [PIX_W-1:0] blk_pixels;
  logic             blk_valid;
  logic             blk_ready;
  logic [IDX_W-1:0] blk_index;
  logic             blk_last;

  modport master (
    output blk_pixels,
    output blk_valid,
    output blk_index,
    output blk_last,
    input  blk_ready
  );

  modport slave (
    input  blk_pixels,
    input  blk_valid,
    input  blk_index,
    input  blk_last,
    output blk_ready
  );

endinterface

// File: rtl/block_row_buffer.sv
// Holds BLK canvas rows and slices out the BLK x BLK block at a given block column.
module block_row_buffer #(
  parameter int unsigned SRC_W  = 56,
  parameter int unsigned BLK    = 2,
  parameter int unsigned COL_W  = 5,
  parameter int unsigned SLOT_W = 1
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [SLOT_W-1:0]    wr_slot,
  input  logic [SRC_W-1:0]     wr_data,
  input  logic [COL_W-1:0]     rd_col,
  output logic [BLK*BLK-1:0]   rd_pix
);

  logic [SRC_W-1:0] rows_q [BLK];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      rows_q[wr_slot] <= wr_data;
    end
  end

  for (genvar j = 0; j < BLK; j++) begin : g_row
    logic [SRC_W-1:0] win;
    assign win = rows_q[j] >> (rd_col * BLK);
    assign rd_pix[j*BLK +: BLK] = win[BLK-1:0];
  end

endmodule

// File: rtl/pixel_block_scanner.sv
// Scans the canvas RAM row-pair by row-pair and streams BLK x BLK pixel blocks in raster order.
module pixel_block_scanner #(
  parameter int unsigned  SRC_W = digit_pkg::SRC_W,
  parameter int unsigned  SRC_H = digit_pkg::SRC_H,
  parameter int unsigned  BLK   = digit_pkg::BLK,
  localparam int unsigned AW    = (SRC_H > 1) ? $clog2(SRC_H) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [SRC_W-1:0]      rd_data,
  output logic                  done,
  pixel_block_scanner_if.master blk
);

  import digit_pkg::*;

  localparam int unsigned OUT_W = SRC_W / BLK;
  localparam int unsigned OUT_H = SRC_H / BLK;
  localparam int unsigned NBLK  = OUT_W * OUT_H;
  localparam int unsigned IW    = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int unsigned CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned SW    = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int unsigned KW    = $clog2(BLK + 2);

  localparam logic [CW-1:0] LAST_C   = CW'(OUT_W - 1);
  localparam logic [RW-1:0] LAST_R   = RW'(OUT_H - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBLK - 1);
  localparam logic [KW-1:0] LAST_RD  = KW'(BLK - 1);
  localparam logic [KW-1:0] LOAD_K   = KW'(BLK + 1);

  state_e           state_q;
  logic [RW-1:0]    r_q;
  logic [CW-1:0]    c_q;
  logic [CW-1:0]    col_sel;
  logic [KW-1:0]    k_q;
  logic [IW-1:0]    nidx_q;
  logic             hs;
  logic             wr_en;
  logic [SW-1:0]    wr_slot;
  logic [BLK*BLK-1:0] buf_pix;

  assign hs      = blk.blk_valid & blk.blk_ready;
  // Read data trails the strobe by one cycle, so slot k-1 lands while k = 1..BLK.
  assign wr_en   = (state_q == StFetch) && (k_q != '0) && (k_q <= KW'(BLK));
  assign wr_slot = SW'(k_q - 1'b1);
  // Look one column ahead on a mid-row handshake so back-to-back blocks need no bubble.
  assign col_sel = (state_q == StEmit && hs && c_q != LAST_C) ? c_q + 1'b1 : c_q;

  block_row_buffer #(
    .SRC_W  (SRC_W),
    .BLK    (BLK),
    .COL_W  (CW),
    .SLOT_W (SW)
  ) u_row_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_slot (wr_slot),
    .wr_data (rd_data),
    .rd_col  (col_sel),
    .rd_pix  (buf_pix)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      r_q            <= '0;
      c_q            <= '0;
      k_q            <= '0;
      nidx_q         <= '0;
      busy           <= 1'b0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      done           <= 1'b0;
      blk.blk_valid  <= 1'b0;
      blk.blk_pixels <= '0;
      blk.blk_index  <= '0;
      blk.blk_last   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            busy    <= 1'b1;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            nidx_q  <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        StFetch: begin
          k_q <= k_q + 1'b1;
          if (k_q == LAST_RD) begin
            rd_en <= 1'b0;
          end else if (rd_en) begin
            rd_addr <= rd_addr + 1'b1;
          end
          if (k_q == LOAD_K) begin
            state_q        <= StEmit;
            blk.blk_valid  <= 1'b1;
            blk.blk_pixels <= buf_pix;
            blk.blk_index  <= nidx_q;
            blk.blk_last   <= (nidx_q == LAST_IDX);
          end
        end
        StEmit: begin
          if (hs) begin
            nidx_q <= nidx_q + 1'b1;
            if (c_q == LAST_C) begin
              c_q           <= '0;
              blk.blk_valid <= 1'b0;
              blk.blk_last  <= 1'b0;
              if (r_q == LAST_R) begin
                state_q <= StFinish;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_q <= StFetch;
                r_q     <= r_q + 1'b1;
                k_q     <= '0;
                rd_en   <= 1'b1;
                rd_addr <= AW'(32'(r_q + 1'b1) * BLK);
              end
            end else begin
              c_q            <= c_q + 1'b1;
              blk.blk_pixels <= buf_pix;
              blk.blk_index  <= nidx_q + 1'b1;
              blk.blk_last   <= ((nidx_q + 1'b1) == LAST_IDX);
            end
          end
        end
        StFinish: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
